// File: rtl/aes_pts_pkg.sv
// Shared types and default geometry for the AES block-to-word serializer.
package aes_pts_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pts_state_t;

    localparam int PTS_WORD_W    = 32;
    localparam int PTS_NUM_WORDS = 4;

endpackage

// File: rtl/pts_word_ptr.sv
// One-hot ring pointer tracking the current beat; is_last marks the final word.
module pts_word_ptr #(
    parameter int NUM_WORDS = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic adv,
    output logic is_last
);

    localparam logic [NUM_WORDS-1:0] PTR_INIT = {{(NUM_WORDS-1){1'b0}}, 1'b1};

    logic [NUM_WORDS-1:0] ptr_q;
    logic [NUM_WORDS-1:0] ptr_d;

    // Next pointer: clear dominates, otherwise rotate left on each beat.
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = PTR_INIT;
        end else if (adv) begin
            ptr_d = {ptr_q[NUM_WORDS-2:0], ptr_q[NUM_WORDS-1]};
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= PTR_INIT;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign is_last = ptr_q[NUM_WORDS-1];

endmodule

// File: rtl/aes_block_pts.sv
// Block-to-word serializer, most-significant word first, valid/ready on both sides.
// Optional build macro: PTS_PARITY_EN adds an even-parity output on out_data.
module aes_block_pts
    import aes_pts_pkg::*;
#(
    parameter int WORD_W    = PTS_WORD_W,
    parameter int NUM_WORDS = PTS_NUM_WORDS
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        clear,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [NUM_WORDS*WORD_W-1:0] load_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W-1:0]           out_data,
    output logic                        out_last
`ifdef PTS_PARITY_EN
    ,
    output logic                        out_parity
`endif
);

    localparam int BLK_W = NUM_WORDS * WORD_W;

    pts_state_t       state_q;
    pts_state_t       state_d;
    logic [BLK_W-1:0] buf_q;
    logic [BLK_W-1:0] buf_d;
    logic             out_valid_q;
    logic             out_valid_d;

    logic beat_s;
    logic is_last_s;
    logic load_ready_s;
    logic load_fire_s;

    assign beat_s       = out_valid_q & out_ready;
    assign load_ready_s = ~clear & ((state_q == IDLE) | (beat_s & is_last_s));
    assign load_fire_s  = load_valid & load_ready_s;

    pts_word_ptr #(
        .NUM_WORDS (NUM_WORDS)
    ) u_word_ptr (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (clear),
        .adv     (beat_s),
        .is_last (is_last_s)
    );

    // Next-state logic; the last beat may reload in the same cycle so blocks run gap-free.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            state_d     = IDLE;
            buf_d       = {BLK_W{1'b0}};
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_fire_s) begin
                        state_d     = SHIFT;
                        buf_d       = load_data;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                    end
                end
                SHIFT: begin
                    if (beat_s && is_last_s && load_fire_s) begin
                        state_d     = SHIFT;
                        buf_d       = load_data;
                        out_valid_d = 1'b1;
                    end else if (beat_s && is_last_s) begin
                        state_d     = IDLE;
                        buf_d       = {BLK_W{1'b0}};
                        out_valid_d = 1'b0;
                    end else if (beat_s) begin
                        buf_d       = buf_q << WORD_W;
                    end else begin
                        buf_d       = buf_q;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    buf_d       = {BLK_W{1'b0}};
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, buffer and valid registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            buf_q       <= {BLK_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign load_ready = load_ready_s;
    assign out_valid  = out_valid_q;
    assign out_data   = buf_q[BLK_W-1 -: WORD_W];
    assign out_last   = out_valid_q & is_last_s;

`ifdef PTS_PARITY_EN
    // Buffer is zero whenever idle, so parity naturally reads 0 there.
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_aes_block_pts.sv
// Directed, table-driven bench for aes_block_pts (WORD_W=32, NUM_WORDS=4).
module tb_aes_block_pts;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 4;
    localparam int NVEC      = 31;

    localparam logic [127:0] BLK1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK2 = 128'hDEADBEEF_0BADF00D_CAFEBABE_01234567;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         load_valid;
    logic         load_ready;
    logic [127:0] load_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
`ifdef PTS_PARITY_EN
    logic         out_parity;
`endif

    typedef struct {
        logic         lv;
        logic [127:0] ld;
        logic         ordy;
        logic         clr;
        logic         e_ov;
        logic [31:0]  e_od;
        logic         e_last;
        logic         e_lr;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_cmp;
    int   n_bad;

    aes_block_pts #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
`ifdef PTS_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic lv, input logic [127:0] ld, input logic ordy,
                                input logic clr, input logic e_ov, input logic [31:0] e_od,
                                input logic e_last, input logic e_lr);
        vec_t v;
        v.lv = lv; v.ld = ld; v.ordy = ordy; v.clr = clr;
        v.e_ov = e_ov; v.e_od = e_od; v.e_last = e_last; v.e_lr = e_lr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_ov, input logic [31:0] e_od,
                            input logic e_last, input logic e_lr);
        chk({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, e_ov});
        chk({tag, ".out_data"},   out_data,            e_od);
        chk({tag, ".out_last"},   {31'd0, out_last},   {31'd0, e_last});
        chk({tag, ".load_ready"}, {31'd0, load_ready}, {31'd0, e_lr});
`ifdef PTS_PARITY_EN
        chk({tag, ".out_parity"}, {31'd0, out_parity}, {31'd0, ^e_od});
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //                lv    data   ordy  clr   ov    data           last  lr
        // basic drain
        vecs[0]  = mk(1'b1, BLK1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        vecs[1]  = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b1, 32'h0011_2233, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b1, 32'h4455_6677, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b1, 32'h8899_AABB, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b1, 32'hCCDD_EEFF, 1'b1, 1'b1);
        vecs[5]  = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        // backpressure on beat 2, then back-to-back into BLK2
        vecs[6]  = mk(1'b1, BLK1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        vecs[7]  = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b1, 32'h0011_2233, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, BLK1, 1'b0, 1'b0, 1'b1, 32'h4455_6677, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, BLK1, 1'b0, 1'b0, 1'b1, 32'h4455_6677, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, BLK1, 1'b0, 1'b0, 1'b1, 32'h4455_6677, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b1, 32'h4455_6677, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b1, 32'h8899_AABB, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, BLK2, 1'b1, 1'b0, 1'b1, 32'hCCDD_EEFF, 1'b1, 1'b1);
        vecs[14] = mk(1'b0, BLK2, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        vecs[15] = mk(1'b1, BLK1, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, BLK2, 1'b1, 1'b0, 1'b1, 32'hCAFE_BABE, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, BLK2, 1'b1, 1'b0, 1'b1, 32'h0123_4567, 1'b1, 1'b1);
        vecs[18] = mk(1'b0, BLK2, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        // clear after beat 2, then a fresh block
        vecs[19] = mk(1'b1, BLK1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        vecs[20] = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b1, 32'h0011_2233, 1'b0, 1'b0);
        vecs[21] = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b1, 32'h4455_6677, 1'b0, 1'b0);
        vecs[22] = mk(1'b1, BLK2, 1'b1, 1'b1, 1'b1, 32'h8899_AABB, 1'b0, 1'b0);
        vecs[23] = mk(1'b0, BLK2, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        vecs[24] = mk(1'b1, BLK2, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        vecs[25] = mk(1'b0, BLK2, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        vecs[26] = mk(1'b0, BLK2, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        vecs[27] = mk(1'b0, BLK2, 1'b1, 1'b0, 1'b1, 32'hCAFE_BABE, 1'b0, 1'b0);
        vecs[28] = mk(1'b0, BLK2, 1'b1, 1'b0, 1'b1, 32'h0123_4567, 1'b1, 1'b1);
        // clear in IDLE suppresses load_ready and the offered load
        vecs[29] = mk(1'b1, BLK1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        vecs[30] = mk(1'b0, BLK1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);

        n_rst      = 1'b0;
        clear      = 1'b0;
        load_valid = 1'b0;
        load_data  = 128'd0;
        out_ready  = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk_outs("reset", 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            load_valid = vecs[i].lv;
            load_data  = vecs[i].ld;
            out_ready  = vecs[i].ordy;
            clear      = vecs[i].clr;
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od,
                     vecs[i].e_last, vecs[i].e_lr);
        end

        // async reset between edges while mid-block
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = BLK1;
        out_ready  = 1'b1;
        clear      = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        #1;
        chk_outs("ar_w0", 1'b1, 32'h0011_2233, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk_outs("ar_async", 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        @(negedge clk);
        n_rst = 1'b1;
        load_valid = 1'b1;
        load_data  = BLK2;
        @(negedge clk);
        load_valid = 1'b0;
        #1;
        chk_outs("ar_reload", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

`ifdef PTS_PARITY_EN
        // odd-parity word on the output
        repeat (4) @(negedge clk);
        load_valid = 1'b1;
        load_data  = 128'h00000001_00000000_00000000_00000000;
        @(negedge clk);
        load_valid = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk("parity_one", {31'd0, out_parity}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
